// File: rtl/sign_compressor_if.sv
// Stream bundle for sign_compressor: input word handshake plus registered output stage.
// master drives words in and consumes results; slave is the compressor itself.
interface sign_compressor_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sign_compressor.sv
// Narrows IN_W-bit two's-complement words to OUT_W bits with clamping, behind one
// registered valid/ready output stage, and keeps a saturating count of clamp events.
module sign_compressor #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sign_compressor_if.slave   bus,
  output logic [CNT_W-1:0]   sat_count,
  input  logic               clr_count
);

  localparam logic [OUT_W-1:0] SatMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SatMin = {1'b1, {(OUT_W-1){1'b0}}};

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                accept;
  logic                xfer;
  logic [IN_W-OUT_W:0] upper;
  logic                fits;
  logic [OUT_W-1:0]    narrow;
  logic                clamp;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = valid_q && bus.out_ready;

  // The word fits when every bit from the output sign position upward matches.
  assign upper = bus.in_data[IN_W-1:OUT_W-1];
  assign fits  = (&upper) || !(|upper);

  always_comb begin
    narrow = bus.in_data[OUT_W-1:0];
    clamp  = 1'b0;
    if (!fits) begin
      clamp  = 1'b1;
      narrow = bus.in_data[IN_W-1] ? SatMin : SatMax;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sat_d   = sat_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = narrow;
      sat_d   = clamp;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (accept && clamp && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sat   = sat_q;
  assign sat_count     = cnt_q;

endmodule

// File: tb/tb_sign_compressor.sv
// Self-checking bench for sign_compressor: directed vector table, hand-written corner
// sequences, and a randomized full sweep against an arithmetic clamp model.
module tb_sign_compressor;

  localparam int IN_W  = 8;
  localparam int OUT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_count = 1'b0;
  logic c_clr = 1'b0;
  logic [7:0] sat_count;
  logic [1:0] c_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sign_compressor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) m_if ();
  sign_compressor_if #(.IN_W(IN_W), .OUT_W(OUT_W)) c_if ();

  sign_compressor #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (m_if.slave),
    .sat_count (sat_count),
    .clr_count (clr_count)
  );

  sign_compressor #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(2)) u_cnt2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (c_if.slave),
    .sat_count (c_count),
    .clr_count (c_clr)
  );

  typedef struct {
    logic [7:0] din;
    logic [1:0] dout;
    logic       sat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clamp computed on signed integers: {sat, data}.
  function automatic logic [2:0] ref_sat(input logic [7:0] x);
    int v, hi, lo, r;
    logic [31:0] rb;
    logic s;
    v  = int'($signed(x));
    hi = (1 << (OUT_W - 1)) - 1;
    lo = -(1 << (OUT_W - 1));
    r  = v;
    s  = 1'b0;
    if (v > hi) begin r = hi; s = 1'b1; end
    if (v < lo) begin r = lo; s = 1'b1; end
    rb = 32'(r);
    return {s, rb[1:0]};
  endfunction

  logic [2:0] q[$];
  int clamped;
  int idx;
  int cycles;
  logic exp_ready;
  logic acc;
  logic xf;
  logic [2:0] e;

  initial begin
    vecs[0] = '{8'hFF, 2'b11, 1'b0};
    vecs[1] = '{8'h00, 2'b00, 1'b0};
    vecs[2] = '{8'h01, 2'b01, 1'b0};
    vecs[3] = '{8'hFE, 2'b10, 1'b0};
    vecs[4] = '{8'h02, 2'b01, 1'b1};
    vecs[5] = '{8'h7F, 2'b01, 1'b1};
    vecs[6] = '{8'hFD, 2'b10, 1'b1};
    vecs[7] = '{8'h80, 2'b10, 1'b1};

    m_if.in_valid = 1'b0; m_if.in_data = 8'h00; m_if.out_ready = 1'b1;
    c_if.in_valid = 1'b0; c_if.in_data = 8'h00; c_if.out_ready = 1'b1;

    // Reset state, with a word offered that must be ignored.
    m_if.in_valid = 1'b1; m_if.in_data = 8'h7F;
    #1;
    check("rst in_ready", 32'(m_if.in_ready), 32'd1);
    step();
    check("rst out_valid", 32'(m_if.out_valid), 32'd0);
    check("rst out_data", 32'(m_if.out_data), 32'd0);
    check("rst out_sat", 32'(m_if.out_sat), 32'd0);
    check("rst sat_count", 32'(sat_count), 32'd0);
    m_if.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Directed table, streamed back to back.
    for (int i = 0; i < 8; i++) begin
      m_if.in_valid = 1'b1;
      m_if.in_data  = vecs[i].din;
      #1;
      check("tbl in_ready", 32'(m_if.in_ready), 32'd1);
      step();
      check($sformatf("tbl[%0d] valid", i), 32'(m_if.out_valid), 32'd1);
      check($sformatf("tbl[%0d] data", i), 32'(m_if.out_data), 32'(vecs[i].dout));
      check($sformatf("tbl[%0d] sat", i), 32'(m_if.out_sat), 32'(vecs[i].sat));
      if (i == 3) check("tbl count0", 32'(sat_count), 32'd0);
    end
    check("tbl count4", 32'(sat_count), 32'd4);

    // Backpressure: held output, blocked input, then simultaneous transfer and accept.
    m_if.in_data = 8'h05;
    step();
    check("bp first", 32'(m_if.out_data), 32'd1);
    m_if.out_ready = 1'b0;
    m_if.in_data   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp in_ready", 32'(m_if.in_ready), 32'd0);
      step();
      check("bp valid", 32'(m_if.out_valid), 32'd1);
      check("bp data", 32'(m_if.out_data), 32'd1);
      check("bp sat", 32'(m_if.out_sat), 32'd1);
    end
    m_if.out_ready = 1'b1;
    #1;
    check("bp release ready", 32'(m_if.in_ready), 32'd1);
    step();
    check("bp next valid", 32'(m_if.out_valid), 32'd1);
    check("bp next data", 32'(m_if.out_data), 32'd0);
    check("bp next sat", 32'(m_if.out_sat), 32'd0);
    m_if.in_valid = 1'b0;
    m_if.in_data  = 8'h80;
    step();
    check("bp drain", 32'(m_if.out_valid), 32'd0);
    check("bp hold data", 32'(m_if.out_data), 32'd0);
    check("bp count", 32'(sat_count), 32'd5);

    // Two-bit counter sticks at 3, and clear beats a concurrent increment.
    c_if.in_valid = 1'b1;
    c_if.in_data  = 8'h7F;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("cnt2[%0d]", i), 32'(c_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    c_clr = 1'b1;
    c_if.in_data = 8'h80;
    step();
    check("cnt2 clr", 32'(c_count), 32'd0);
    c_clr = 1'b0;
    c_if.in_valid = 1'b0;

    // Mid-stream reset while a clamped word is held.
    m_if.in_valid  = 1'b1;
    m_if.in_data   = 8'h80;
    m_if.out_ready = 1'b0;
    step();
    m_if.in_valid = 1'b0;
    check("mid held", 32'(m_if.out_data), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid valid", 32'(m_if.out_valid), 32'd0);
    check("mid data", 32'(m_if.out_data), 32'd0);
    check("mid count", 32'(sat_count), 32'd0);
    step();
    rst_n = 1'b1;
    m_if.out_ready = 1'b1;
    m_if.in_valid  = 1'b1;
    m_if.in_data   = 8'h01;
    step();
    check("post valid", 32'(m_if.out_valid), 32'd1);
    check("post data", 32'(m_if.out_data), 32'd1);
    check("post sat", 32'(m_if.out_sat), 32'd0);
    m_if.in_valid = 1'b0;
    step();

    // Randomized sweep of every input value against the clamp model.
    q.delete();
    clamped = 0;
    idx     = 0;
    cycles  = 0;
    while (idx < 256 && cycles < 5000) begin
      m_if.in_valid  = ($urandom_range(3) != 0);
      m_if.in_data   = m_if.in_valid ? 8'(idx) : 8'($urandom);
      m_if.out_ready = $urandom_range(1) == 1;
      #1;
      exp_ready = (q.size() == 0) || m_if.out_ready;
      check("swp in_ready", 32'(m_if.in_ready), 32'(exp_ready));
      xf  = (q.size() != 0) && m_if.out_ready;
      acc = m_if.in_valid && exp_ready;
      step();
      if (xf) void'(q.pop_front());
      if (acc) begin
        e = ref_sat(8'(idx));
        q.push_back(e);
        if (e[2]) clamped++;
        idx++;
      end
      check("swp valid", 32'(m_if.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("swp data", 32'(m_if.out_data), 32'(q[0][1:0]));
        check("swp sat", 32'(m_if.out_sat), 32'(q[0][2]));
      end
      cycles++;
    end
    check("swp all accepted", 32'(idx), 32'd256);
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    step();
    check("swp drained", 32'(m_if.out_valid), 32'd0);
    check("swp count", 32'(sat_count), 32'((clamped > 255) ? 255 : clamped));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sign_compressor.md
Name: sign_compressor

Overview:
- Inverse direction of the 2-bit→8-bit sign-extension path: narrows a stream of IN_W-bit two's-complement words back to OUT_W bits.
- Clamps to the OUT_W range instead of wrapping, and flags every clamped word.
- Keeps a saturating count of clamp events for status readback.
- Sits between the datapath and any narrow sign-field consumer, behind one registered valid/ready output stage.

Parameters:
- IN_W, 8, input word width (two's complement); IN_W > OUT_W.
- OUT_W, 2, output word width (two's complement); OUT_W >= 2.
- CNT_W, 8, width of the saturation-event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  IN_W  signed input word.
- out_valid  output  1  out_data/out_sat are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  OUT_W  narrowed, saturated word.
- out_sat  output  1  out_data was clamped.
- sat_count  output  CNT_W  number of accepted words that were clamped.
- clr_count  input  1  synchronous clear of sat_count.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sat=0, sat_count=0.
- While in reset, in_ready is combinationally 1 but no state changes.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle from accept to out_valid=1. Full throughput (1 word/cycle) while out_ready=1.
- Output register, evaluated each edge:
  - On accept: out_data <= sat(in_data), out_sat <= clamp flag, out_valid <= 1.
  - Else on output transfer: out_valid <= 0. out_data/out_sat hold their last value.
  - Else: all hold. Output stays stable while out_valid && !out_ready.
- Simultaneous output transfer and accept in the same cycle: the new word replaces the old one and out_valid stays 1, with no bubble.
- Saturation rule:
  - MAX = 2^(OUT_W-1)-1, MIN = -2^(OUT_W-1).
  - Fits iff in_data[IN_W-1:OUT_W-1] are all equal. Then out_data = in_data[OUT_W-1:0] and the clamp flag is 0.
  - Else if in_data[IN_W-1]=0: out_data = MAX, clamp flag = 1.
  - Else: out_data = MIN, clamp flag = 1.
  - For OUT_W=2: range -2..+1, so MAX=2'b01 and MIN=2'b10.
- Counter:
  - Increments by 1 on each accept whose clamp flag is 1.
  - Sticks at all-ones and never wraps.
  - clr_count=1 sets it to 0 on the next edge. Clear wins over a simultaneous increment (result 0).
- Round-trip property: sign-extending any OUT_W value to IN_W and feeding it through the block returns the same value with out_sat=0.
- Mid-stream reset: the in-flight output word is discarded, out_valid drops immediately, sat_count=0. The first accept after release behaves as after power-up.
- in_data is ignored when no accept occurs.

Test Plan:
- Reset, then stream 8'hFF, 8'h00, 8'h01, 8'hFE with out_ready=1 → out_data 2'b11, 2'b00, 2'b01, 2'b10 on consecutive cycles, 1 cycle after each accept; out_sat=0 throughout; sat_count=0.
- Inputs 8'h02, 8'h7F, 8'hFD, 8'h80 → out_data 2'b01, 2'b01, 2'b10, 2'b10; out_sat=1 for each; sat_count=4.
- Backpressure: accept 8'h05, hold out_ready=0 for 3 cycles while presenting 8'h00 → in_ready=0, out_data=2'b01 and out_sat=1 held stable, 8'h00 not consumed. Raise out_ready → 8'h00 accepted in the same cycle the first word transfers, and the next output is 2'b00.
- Counter: with CNT_W=2, send 5 clamped words → sat_count 1, 2, 3, 3, 3. Then assert clr_count in the same cycle as a clamped accept → sat_count=0.
- Assert rst_n low while out_valid=1 holding 2'b10 → out_valid=0, out_data=0, sat_count=0 immediately. After release, 8'h01 → 2'b01 one cycle later.
- Exhaustive sweep: all 256 in_data values with out_ready random → every output matches the saturation rule; sat_count equals min(number clamped, 255), which is 252 clamped words for OUT_W=2.
